// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU run/step/halt clock controller.
// Latency: n/a (constants only).  Backpressure: n/a.
package cpu_clk_pkg;
    localparam logic [1:0] ST_HALT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STEP     = 2'd2;
    localparam int         SYNC_STAGES = 2;
endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Debounces an already-synchronised button level; emits a pulse on accepted 0->1.
// Latency: DB_CYCLES clk of stable input, then level/rise registered.  Backpressure: none.
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);
    localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    // Counter only runs while input disagrees with the accepted level; any agreement restarts it.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (din != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = din;
                rise_d  = din;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt controller issuing one-clk cpu_ce pulses per divided-clock rise; optional BREAKPOINT_EN.
// Latency: tick_in rise -> cpu_ce 3 clk (2 sync + registered output).  Backpressure: none, at most one ce per tick.
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             step_btn,
    input  logic             run_sw,
    input  logic             halt_in,
    input  logic [31:0]      pc,
    input  logic [31:0]      bp_addr,
    output logic             cpu_ce,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             halted
);
    logic [SYNC_STAGES-1:0] tick_sync_q, tick_sync_d;
    logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
    logic [SYNC_STAGES-1:0] run_sync_q, run_sync_d;
    logic                   tick_prev_q, tick_prev_d;
    logic [1:0]             state_q, state_d;
    logic                   ce_q, ce_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   halted_q, halted_d;
    logic                   tick_rise, run_s, step_req, btn_level, bp_hit;

`ifdef BREAKPOINT_EN
    assign bp_hit = (pc == bp_addr);
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr};
    assign bp_hit    = 1'b0;
`endif

    assign tick_rise = tick_sync_q[SYNC_STAGES-1] & ~tick_prev_q;
    assign run_s     = run_sync_q[SYNC_STAGES-1];

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_sync_q[SYNC_STAGES-1]),
        .level (btn_level),
        .rise  (step_req)
    );

    always_comb begin
        tick_sync_d = {tick_sync_q[SYNC_STAGES-2:0], tick_in};
        btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], step_btn};
        run_sync_d  = {run_sync_q[SYNC_STAGES-2:0], run_sw};
        tick_prev_d = tick_sync_q[SYNC_STAGES-1];
        state_d     = state_q;
        ce_d        = 1'b0;
        unique case (state_q)
            ST_HALT: begin
                if (run_s && !halt_in && !bp_hit) state_d = ST_RUN;
                else if (step_req)                state_d = ST_STEP;
            end
            // Leaving RUN suppresses a coincident tick so the core never advances past a halt.
            ST_RUN: begin
                if (halt_in || !run_s || bp_hit) state_d = ST_HALT;
                else if (tick_rise)              ce_d    = 1'b1;
            end
            ST_STEP: begin
                if (tick_rise) begin
                    ce_d    = 1'b1;
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_HALT;
        endcase
        cnt_d    = cnt_q + CNT_W'(ce_d);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_sync_q <= '0;
            btn_sync_q  <= '0;
            run_sync_q  <= '0;
            tick_prev_q <= 1'b0;
            state_q     <= ST_HALT;
            ce_q        <= 1'b0;
            cnt_q       <= '0;
            halted_q    <= 1'b1;
        end else begin
            tick_sync_q <= tick_sync_d;
            btn_sync_q  <= btn_sync_d;
            run_sync_q  <= run_sync_d;
            tick_prev_q <= tick_prev_d;
            state_q     <= state_d;
            ce_q        <= ce_d;
            cnt_q       <= cnt_d;
            halted_q    <= halted_d;
        end
    end

    logic unused_level;
    assign unused_level = btn_level;

    assign cpu_ce    = ce_q;
    assign cycle_cnt = cnt_q;
    assign halted    = halted_q;
endmodule
